// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Request record; packed so addr lands at [64:33], iswrite at [32], data at [31:0]
  typedef struct packed {
    logic [31:0] addr;
    logic        iswrite;
    logic [31:0] data;
  } mem_req_t;

  localparam int REQ_W        = 65;
  localparam int REQ_ADDR_MSB = 64;
  localparam int REQ_ADDR_LSB = 33;
  localparam int REQ_WR_BIT   = 32;
  localparam int REQ_DATA_MSB = 31;
  localparam int REQ_DATA_LSB = 0;

  // Read data returned when the watchdog gives up on the slave
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  // Build a request record from its fields
  function automatic mem_req_t make_req(input logic [31:0] addr,
                                        input logic        iswrite,
                                        input logic [31:0] data);
    mem_req_t r;
    r.addr    = addr;
    r.iswrite = iswrite;
    r.data    = data;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: a lone requester wins outright; under contention
// the master that did not win last time is chosen.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant
);

  // Pick the winner purely from the current valids and the previous winner
  always_comb begin
    o_grant_valid = i_valid0 | i_valid1;
    o_grant       = 1'b0;
    if (i_valid0 && i_valid1) begin
      o_grant = ~i_last_grant;
    end else if (i_valid1) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave memory bus arbiter with a single outstanding request.
// Optional slave watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // master 0
  input  logic              i_m0_rq_valid,
  output logic              o_m0_rq_ready,
  input  logic [ADDR_W-1:0] i_m0_rq_addr,
  input  logic              i_m0_rq_iswrite,
  input  logic [DATA_W-1:0] i_m0_rq_data,
  output logic              o_m0_rs_valid,
  input  logic              i_m0_rs_ready,
  output logic [DATA_W-1:0] o_m0_rs_data,
  output logic              o_m0_rs_err,
  // master 1
  input  logic              i_m1_rq_valid,
  output logic              o_m1_rq_ready,
  input  logic [ADDR_W-1:0] i_m1_rq_addr,
  input  logic              i_m1_rq_iswrite,
  input  logic [DATA_W-1:0] i_m1_rq_data,
  output logic              o_m1_rs_valid,
  input  logic              i_m1_rs_ready,
  output logic [DATA_W-1:0] o_m1_rs_data,
  output logic              o_m1_rs_err,
  // slave
  output logic              o_s_rq_valid,
  input  logic              i_s_rq_ready,
  output logic [ADDR_W-1:0] o_s_rq_addr,
  output logic              o_s_rq_iswrite,
  output logic [DATA_W-1:0] o_s_rq_data,
  input  logic              i_s_rs_valid,
  output logic              o_s_rs_ready,
  input  logic [DATA_W-1:0] i_s_rs_data
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic              r_last_grant;
  logic              r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic              r_iswrite;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rs_data;
  logic              r_rs_err;

  logic              w_grant_valid;
  logic              w_grant;
  logic              w_accept;
  logic              w_rs_hs;
  logic              w_timeout;
  logic              w_stale;

  mem_arb_rr u_rr (
    .i_valid0      (i_m0_rq_valid),
    .i_valid1      (i_m1_rq_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  // A grant is only taken in IDLE, and never while a timed-out response is still owed
  assign w_accept = (r_state == IDLE) && w_grant_valid && !w_stale;
  assign w_rs_hs  = (r_state == RESP) && (r_grant ? i_m1_rs_ready : i_m0_rs_ready);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next  = r_state;
    o_m0_rq_ready = 1'b0;
    o_m1_rq_ready = 1'b0;
    o_s_rq_valid  = 1'b0;
    o_s_rs_ready  = w_stale;
    o_m0_rs_valid = 1'b0;
    o_m1_rs_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        // ready is gated by reset so a master never sees an acceptance during reset
        o_m0_rq_ready = i_rst_n & w_accept & ~w_grant;
        o_m1_rq_ready = i_rst_n & w_accept & w_grant;
        if (w_accept) w_state_next = ISSUE;
      end
      ISSUE: begin
        o_s_rq_valid = 1'b1;
        if (i_s_rq_ready) w_state_next = WAIT;
      end
      WAIT: begin
        o_s_rs_ready = 1'b1;
        if (i_s_rs_valid || w_timeout) w_state_next = RESP;
      end
      RESP: begin
        o_m0_rs_valid = ~r_grant;
        o_m1_rs_valid = r_grant;
        if (w_rs_hs) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request register: latch the winner's fields and remember who won
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= '0;
      r_iswrite    <= 1'b0;
      r_wdata      <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
      r_grant      <= w_grant;
      r_addr       <= w_grant ? i_m1_rq_addr    : i_m0_rq_addr;
      r_iswrite    <= w_grant ? i_m1_rq_iswrite : i_m0_rq_iswrite;
      r_wdata      <= w_grant ? i_m1_rq_data    : i_m0_rq_data;
    end
  end

  // Response register: slave data (zeroed for write acks) or the timeout pattern
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rs_data <= '0;
    end else if (r_state == WAIT) begin
      if (i_s_rs_valid) begin
        r_rs_data <= r_iswrite ? '0 : i_s_rs_data;
      end else if (w_timeout) begin
        r_rs_data <= DATA_W'(TIMEOUT_DATA);
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wait_cnt;
  logic       r_stale;

  assign w_timeout = (r_state == WAIT) && !i_s_rs_valid && (r_wait_cnt == TO_LAST);
  assign w_stale   = r_stale;

  // WAIT-cycle counter, zero on every entry into WAIT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Stale flag: the abandoned slave response is still to come and must be swallowed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stale <= 1'b0;
    end else if (w_timeout) begin
      r_stale <= 1'b1;
    end else if (r_stale && i_s_rs_valid) begin
      r_stale <= 1'b0;
    end
  end

  // Error flag travels with the response data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rs_err <= 1'b0;
    end else if (r_state == WAIT) begin
      if (i_s_rs_valid) begin
        r_rs_err <= 1'b0;
      end else if (w_timeout) begin
        r_rs_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_stale   = 1'b0;
  assign r_rs_err  = 1'b0;
`endif

  assign o_s_rq_addr    = r_addr;
  assign o_s_rq_iswrite = r_iswrite;
  assign o_s_rq_data    = r_wdata;
  assign o_m0_rs_data   = r_rs_data;
  assign o_m1_rs_data   = r_rs_data;
  assign o_m0_rs_err    = r_rs_err;
  assign o_m1_rs_err    = r_rs_err;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave memory bus arbiter placed between the processor core's memory request/response interface, a second master (debug/program loader), and the shared ROM/RAM/MMIO memory port. It grants the port round-robin, forwards exactly one outstanding request at a time, and routes the single response back to the granting master. An optional watchdog returns an error response when the slave never answers.

## Interface
Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, request/response data width
- TIMEOUT_CYCLES, 64, WAIT-state cycles before the watchdog fires (used only with MEM_ARB_TIMEOUT_EN); range 1..255

Ports (i = 0, 1):
- CLK  in  1  single clock; all state on rising edge
- RST_N  in  1  reset; asynchronous, active-low
- m<i>_rq_valid  in  1  master i request valid; held until accepted
- m<i>_rq_ready  out  1  master i request accepted this cycle
- m<i>_rq_addr  in  ADDR_W  request address
- m<i>_rq_iswrite  in  1  1 = write, 0 = read
- m<i>_rq_data  in  DATA_W  write data; ignored for reads
- m<i>_rs_valid  out  1  response to master i valid
- m<i>_rs_ready  in  1  master i takes the response
- m<i>_rs_data  out  DATA_W  read data; 0 for write acks
- m<i>_rs_err  out  1  response produced by the watchdog
- s_rq_valid / s_rq_ready  out / in  1  slave request handshake
- s_rq_addr, s_rq_iswrite, s_rq_data  out  ADDR_W, 1, DATA_W  registered request
- s_rs_valid / s_rs_ready  in / out  1  slave response handshake
- s_rs_data  in  DATA_W  slave response data

## Operation
- Contract: every request, read or write, gets exactly one slave response. Write responses carry don't-care data.
- FSM states and transitions:
  - IDLE -> ISSUE on grant.
  - ISSUE -> WAIT on s_rq handshake.
  - WAIT -> RESP on s_rs handshake or on watchdog.
  - RESP -> IDLE on m<g>_rs handshake.
- IDLE:
  - Grant = the only valid master. If both are valid, grant the master opposite last_grant.
  - m<g>_rq_ready = 1 combinationally for that cycle only.
  - Capture addr/iswrite/data into the request register, latch g, update last_grant.
- ISSUE: s_rq_valid = 1 with the registered fields, held stable until s_rq_ready.
- WAIT:
  - s_rs_ready = 1.
  - On s_rs_valid, capture s_rs_data (write: store 0).
- RESP: m<g>_rs_valid = 1, data/err stable until m<g>_rs_ready. The other master's rs_valid stays 0.
- Valid inputs never depend on ready outputs. The arbiter never deasserts a valid before its handshake completes.
- Reset values:
  - State IDLE, last_grant = 1, so master 0 wins the first contention.
  - All valid/ready outputs 0; all data/addr outputs 0; err 0; stale 0.
  - m<i>_rq_ready is forced 0 while RST_N is low.
- Reset asserted mid-transaction: immediate return to IDLE. The in-flight transaction is abandoned with no response.

## Timing
- Minimum transaction: 4 cycles (grant, issue, response accept, response deliver) when the slave answers in the cycle after accepting. Next grant is possible in the cycle after the RESP handshake.
- Request-to-slave latency: s_rq_valid rises in the cycle after m_rq_ready.
- A slave response presented before WAIT waits (s_rs_ready = 0 outside WAIT, except the stale drain).
- Both masters valid continuously: grants alternate 0,1,0,1. Neither master starves; worst-case wait is one transaction.
- Simultaneous new m_rq_valid in RESP: ignored until IDLE.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - The WAIT counter is cleared on entry and increments each WAIT cycle.
  - At TIMEOUT_CYCLES without a response: go to RESP with rs_data = 32'hDEADBEEF and rs_err = 1, and set stale.
  - While stale is set, s_rs_ready = 1 in every state. The next s_rs handshake is consumed, dropped, and clears stale.
  - No new ISSUE begins while stale is set; IDLE holds grants.
- Undefined: no counter; WAIT lasts indefinitely; m<i>_rs_err tied 0; stale logic absent.

## Structure
- Package mem_arb_pkg:
  - State enum {IDLE, ISSUE, WAIT, RESP}.
  - Request record type (addr, iswrite, data).
  - TIMEOUT_DATA = 32'hDEADBEEF.
  - Packed-request field positions: addr [64:33], iswrite [32], data [31:0] (65 bits total).
- Sub-module mem_arb_rr: 2-way round-robin grant from {valid0, valid1, last_grant}, purely combinational.
- Top: FSM, request/response registers, optional watchdog.

## Test plan
- Master 0 reads 0x0000_0010; slave answers 32'h1234_5678 after 1 cycle -> m0_rs_data = 32'h1234_5678, err 0, total 4 cycles, m1 sees no rs_valid.
- Both masters valid from reset, 6 back-to-back reads -> slave sees order m0, m1, m0, m1, m0, m1; each response is routed to the matching master.
- Master 1 writes 32'hCAFE_F00D to 0x400; slave holds s_rq_ready low 3 cycles -> s_rq_* stable throughout; single ack to m1.
- m0_rs_ready held low 5 cycles in RESP -> rs_valid/data stable; no new grant until the handshake.
- RST_N dropped during WAIT -> next cycle all outputs 0 and state IDLE; after release, m0 wins contention.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave silent -> after 8 WAIT cycles, m0 receives 32'hDEADBEEF with err = 1. A late s_rs is dropped, and m1's following request completes normally.
